// File: rtl/seq_scan_ctrl.sv
// seq_scan_ctrl
//   Front-end controller for a SequenceDetector. Parallel words arrive on a
//   valid/ready handshake and are serialized one bit per clock onto the
//   detector's data input. The detector is held in reset between streams.
//   Qualified detector pulses are counted, and the per-stream result is
//   offered on a second valid/ready handshake.
//
// Ports
//   clk           system clock, rising edge
//   reset         asynchronous, active-low reset
//   in_valid      in_word / in_last valid
//   in_ready      word accepted this cycle when in_valid is also high
//   in_word       word to serialize
//   in_last       accepted word ends the stream
//   det_reset     active-high reset to the detector
//   det_data_in   serial bit to the detector
//   det_detected  detector match output
//   out_valid     result available
//   out_ready     consumer takes the result
//   out_count     matches counted in the stream (saturating)
//   out_overflow  a match arrived while the count was saturated
//   out_underrun  stream aborted: no word at a word boundary
//   busy          controller not idle
module seq_scan_ctrl #(
  parameter int WORD_W    = 8,
  parameter int CNT_W     = 8,
  parameter int MSB_FIRST = 1,
  parameter int DET_LAT   = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_word,
  input  logic              in_last,
  output logic              det_reset,
  output logic              det_data_in,
  input  logic              det_detected,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  out_count,
  output logic              out_overflow,
  output logic              out_underrun,
  output logic              busy
);

  localparam int BIT_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WORD_W - 1);
  localparam int DRAIN_LAST_I = (DET_LAT > 0) ? DET_LAT - 1 : 0;
  localparam logic [1:0] DRAIN_LAST = DRAIN_LAST_I[1:0];

  typedef enum logic [1:0] {IDLE, SHIFT, DRAIN, REPORT} state_t;

  state_t             state, state_nxt;
  logic [WORD_W-1:0]  shift_q;
  logic [BIT_W-1:0]   bit_idx;
  logic               last_q;
  logic [1:0]         drain_cnt;
  logic               cur_bit;
  logic               bit_last;
  logic               accept;
  logic               vld_p0;
  logic               vld_det;
  logic               det_hit;
  logic [CNT_W:0]     inc_res;

  // Saturating increment: returns {lost_match, next_count}.
  function automatic logic [CNT_W:0] sat_inc(input logic [CNT_W-1:0] c);
    if (&c) return {1'b1, c};
    else    return {1'b0, c + 1'b1};
  endfunction

  assign cur_bit  = (MSB_FIRST != 0) ? shift_q[WORD_W-1] : shift_q[0];
  assign bit_last = (bit_idx == BIT_LAST);
  assign accept   = in_valid && in_ready;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state and state-decoded outputs
  always_comb begin
    state_nxt   = state;
    in_ready    = 1'b0;
    det_reset   = 1'b0;
    det_data_in = 1'b0;
    out_valid   = 1'b0;
    busy        = 1'b1;
    case (state)
      IDLE: begin
        in_ready  = 1'b1;
        det_reset = 1'b1;
        busy      = 1'b0;
        if (in_valid) state_nxt = SHIFT;
      end
      SHIFT: begin
        det_data_in = cur_bit;
        in_ready    = bit_last && !last_q;
        // A missing next word aborts into the same drain path as a last word.
        if (bit_last && (last_q || !in_valid))
          state_nxt = (DET_LAT == 0) ? REPORT : DRAIN;
      end
      DRAIN: begin
        if (drain_cnt == DRAIN_LAST) state_nxt = REPORT;
      end
      REPORT: begin
        det_reset = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Stage p0: serializer; every accept reloads, otherwise shift each SHIFT cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shift_q   <= '0;
      bit_idx   <= '0;
      last_q    <= 1'b0;
      drain_cnt <= '0;
    end else begin
      if (accept) begin
        shift_q <= in_word;
        last_q  <= in_last;
        bit_idx <= '0;
      end else if (state == SHIFT) begin
        shift_q <= (MSB_FIRST != 0) ? {shift_q[WORD_W-2:0], 1'b0}
                                    : {1'b0, shift_q[WORD_W-1:1]};
        bit_idx <= bit_idx + 1'b1;
      end
      if (state == DRAIN) drain_cnt <= drain_cnt + 1'b1;
      else                drain_cnt <= '0;
    end
  end

  assign vld_p0 = (state == SHIFT);

  // Stage p1..pDET_LAT: bit-valid pipe aligned with the detector response
  generate
    if (DET_LAT == 0) begin : g_vld_none
      assign vld_det = vld_p0;
    end else if (DET_LAT == 1) begin : g_vld_one
      logic vld_p1;
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) vld_p1 <= 1'b0;
        else        vld_p1 <= vld_p0;
      end
      assign vld_det = vld_p1;
    end else begin : g_vld_multi
      logic [DET_LAT-1:0] vld_pn;
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) vld_pn <= '0;
        else        vld_pn <= {vld_pn[DET_LAT-2:0], vld_p0};
      end
      assign vld_det = vld_pn[DET_LAT-1];
    end
  endgenerate

  assign det_hit = vld_det && det_detected;
  assign inc_res = sat_inc(out_count);

  // Result registers: cleared on the first-word accept, held through REPORT
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_count    <= '0;
      out_overflow <= 1'b0;
      out_underrun <= 1'b0;
    end else if (state == IDLE && accept) begin
      out_count    <= '0;
      out_overflow <= 1'b0;
      out_underrun <= 1'b0;
    end else begin
      if (det_hit) begin
        out_count    <= inc_res[CNT_W-1:0];
        out_overflow <= out_overflow | inc_res[CNT_W];
      end
      if (state == SHIFT && bit_last && !last_q && !in_valid)
        out_underrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_seq_scan_ctrl.sv
// Directed bench for seq_scan_ctrl with an overlapping "101" detector model
// (registered output, synchronous active-high reset). Two controllers share
// the stimulus: one with an 8-bit count, one with a 2-bit count.
module tb_seq_scan_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic [7:0] in_word;
  logic       in_last;
  logic       out_ready;

  logic       in_ready_a, det_reset_a, det_data_a, det_a, out_valid_a;
  logic       ovf_a, udr_a, busy_a;
  logic [7:0] cnt_a;
  logic       in_ready_b, det_reset_b, det_data_b, det_b, out_valid_b;
  logic       ovf_b, udr_b, busy_b;
  logic [1:0] cnt_b;

  logic [1:0] hist_a = 2'b00;
  logic [1:0] hist_b = 2'b00;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  seq_scan_ctrl #(.WORD_W(8), .CNT_W(8), .MSB_FIRST(1), .DET_LAT(1)) dut_a (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_a),
    .in_word(in_word), .in_last(in_last), .det_reset(det_reset_a),
    .det_data_in(det_data_a), .det_detected(det_a), .out_valid(out_valid_a),
    .out_ready(out_ready), .out_count(cnt_a), .out_overflow(ovf_a),
    .out_underrun(udr_a), .busy(busy_a)
  );

  seq_scan_ctrl #(.WORD_W(8), .CNT_W(2), .MSB_FIRST(1), .DET_LAT(1)) dut_b (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_b),
    .in_word(in_word), .in_last(in_last), .det_reset(det_reset_b),
    .det_data_in(det_data_b), .det_detected(det_b), .out_valid(out_valid_b),
    .out_ready(out_ready), .out_count(cnt_b), .out_overflow(ovf_b),
    .out_underrun(udr_b), .busy(busy_b)
  );

  // Overlapping "101" detectors, one per controller
  always @(posedge clk) begin
    if (det_reset_a) begin
      hist_a <= 2'b00;
      det_a  <= 1'b0;
    end else begin
      det_a  <= ({hist_a, det_data_a} == 3'b101);
      hist_a <= {hist_a[0], det_data_a};
    end
  end

  always @(posedge clk) begin
    if (det_reset_b) begin
      hist_b <= 2'b00;
      det_b  <= 1'b0;
    end else begin
      det_b  <= ({hist_b, det_data_b} == 3'b101);
      hist_b <= {hist_b[0], det_data_b};
    end
  end

  task automatic chk1(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [15:0] stream;

  initial begin
    reset     = 1'b0;
    in_valid  = 1'b0;
    in_word   = 8'h00;
    in_last   = 1'b0;
    out_ready = 1'b0;

    // ---- reset state
    #12;
    chk1("rst_det_reset", det_reset_a, 1'b1);
    chk1("rst_det_data", det_data_a, 1'b0);
    chk1("rst_out_valid", out_valid_a, 1'b0);
    chk1("rst_busy", busy_a, 1'b0);
    chk1("rst_in_ready", in_ready_a, 1'b1);
    chk8("rst_count", cnt_a, 8'd0);
    chk1("rst_ovf", ovf_a, 1'b0);
    chk1("rst_udr", udr_a, 1'b0);
    reset = 1'b1;
    tick();

    // ---- single word A8, last
    in_word = 8'hA8; in_last = 1'b1; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk1("t1_det_reset_low", det_reset_a, 1'b0);
    chk1("t1_busy", busy_a, 1'b1);
    stream = 16'hA800;
    for (int k = 0; k < 8; k++) begin
      chk1("t1_bit", det_data_a, stream[15-k]);
      chk1("t1_in_ready", in_ready_a, 1'b0);
      chk1("t1_no_valid", out_valid_a, 1'b0);
      tick();
    end
    chk1("t1_drain_data", det_data_a, 1'b0);
    chk1("t1_drain_no_valid", out_valid_a, 1'b0);
    tick();
    chk1("t1_out_valid", out_valid_a, 1'b1);
    chk8("t1_count", cnt_a, 8'd2);
    chk1("t1_ovf", ovf_a, 1'b0);
    chk1("t1_udr", udr_a, 1'b0);
    chk1("t1_det_reset_rep", det_reset_a, 1'b1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk1("t1_idle_busy", busy_a, 1'b0);
    chk1("t1_idle_valid", out_valid_a, 1'b0);
    chk8("t1_count_held", cnt_a, 8'd2);

    // ---- two gapless words A5, 40 (last)
    in_word = 8'hA5; in_last = 1'b0; in_valid = 1'b1;
    tick();
    in_word = 8'h40; in_last = 1'b1;
    stream = 16'hA540;
    for (int k = 0; k < 16; k++) begin
      if (k == 8) in_valid = 1'b0;
      chk1("t2_bit", det_data_a, stream[15-k]);
      chk1("t2_in_ready", in_ready_a, (k == 7));
      tick();
    end
    chk1("t2_drain_no_valid", out_valid_a, 1'b0);
    tick();
    chk1("t2_out_valid", out_valid_a, 1'b1);
    chk8("t2_count", cnt_a, 8'd3);
    chk8("t2_count_b", {6'd0, cnt_b}, 8'd3);
    chk1("t2_ovf", ovf_a, 1'b0);
    chk1("t2_udr", udr_a, 1'b0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // ---- saturation: AA, AA (last) -> 7 matches
    in_word = 8'hAA; in_last = 1'b0; in_valid = 1'b1;
    tick();
    in_last = 1'b1;
    for (int k = 0; k < 16; k++) begin
      if (k == 8) in_valid = 1'b0;
      tick();
    end
    tick();
    chk1("t3_out_valid", out_valid_a, 1'b1);
    chk8("t3_count_a", cnt_a, 8'd7);
    chk1("t3_ovf_a", ovf_a, 1'b0);
    chk8("t3_count_b", {6'd0, cnt_b}, 8'd3);
    chk1("t3_ovf_b", ovf_b, 1'b1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk1("t3_idle", busy_b, 1'b0);

    // ---- underrun: A5 not last, no next word
    in_word = 8'hA5; in_last = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk1("t4_ovf_cleared", ovf_b, 1'b0);
    stream = 16'hA500;
    for (int k = 0; k < 8; k++) begin
      chk1("t4_bit", det_data_a, stream[15-k]);
      chk1("t4_in_ready", in_ready_a, (k == 7));
      tick();
    end
    chk1("t4_drain_busy", busy_a, 1'b1);
    chk1("t4_drain_no_valid", out_valid_a, 1'b0);
    tick();
    chk1("t4_out_valid", out_valid_a, 1'b1);
    chk1("t4_udr", udr_a, 1'b1);
    chk8("t4_count", cnt_a, 8'd2);
    chk1("t4_ovf", ovf_a, 1'b0);

    // ---- back-pressure in REPORT
    for (int k = 0; k < 5; k++) begin
      tick();
      chk1("t5_valid_hold", out_valid_a, 1'b1);
      chk8("t5_count_hold", cnt_a, 8'd2);
      chk1("t5_udr_hold", udr_a, 1'b1);
      chk1("t5_det_reset", det_reset_a, 1'b1);
      chk1("t5_in_ready", in_ready_a, 1'b0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk1("t5_idle_valid", out_valid_a, 1'b0);
    chk1("t5_idle_busy", busy_a, 1'b0);
    chk1("t5_udr_kept", udr_a, 1'b1);

    // ---- reset mid-SHIFT at bit 4
    in_word = 8'hA8; in_last = 1'b1; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    chk1("t6_bit4", det_data_a, 1'b1);
    chk8("t6_count_mid", cnt_a, 8'd1);
    reset = 1'b0;
    #2;
    chk1("t6_det_reset", det_reset_a, 1'b1);
    chk1("t6_out_valid", out_valid_a, 1'b0);
    chk1("t6_busy", busy_a, 1'b0);
    chk8("t6_count", cnt_a, 8'd0);
    chk1("t6_udr", udr_a, 1'b0);
    chk1("t6_det_data", det_data_a, 1'b0);
    reset = 1'b1;
    tick();
    chk1("t6_idle_after", busy_a, 1'b0);

    // ---- fresh stream after reset
    in_word = 8'hA8; in_last = 1'b1; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 8; k++) tick();
    tick();
    chk1("t7_out_valid", out_valid_a, 1'b1);
    chk8("t7_count", cnt_a, 8'd2);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk1("t7_idle", busy_a, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
